// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width, the x0 register and a
// one-hot to index helper used by the writeback arbiter.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int IDX_W = 3;
  localparam int MAX_REQ = 8;

  function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past rr_ptr and the
// first valid requester wins. Produces a one-hot grant and its index.
module rr_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W:0]   cand;
  logic [MAX_REQ-1:0] grant_ext;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = {1'b0, rr_ptr};
    for (int k = 0; k < NREQ; k++) begin
      cand = cand + 1'b1;
      // NREQ need not be a power of two, so wrap by compare rather than mask
      if (cand >= (IDX_W+1)'(NREQ)) cand = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && valid[i] && (cand == (IDX_W+1)'(i))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign grant_ext = MAX_REQ'(grant);
  assign grant_idx = onehot2idx(grant_ext);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NREQ writeback sources with
// round-robin arbitration. Define WB_ARB_OUTREG_EN to flop the rf_* outputs.
//
// Handshake: requester i transfers when req_valid[i] && req_ready[i] at a rising
// clk edge; it holds valid/wa/wd stable until then and never drops valid early.
// req_ready is one-hot on the arbitration winner, or zero when nothing is valid.
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*5-1:0]       req_wa,
  input  logic [NREQ*WIDTH-1:0]   req_wd,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_wa,
  output logic [WIDTH-1:0]        rf_wd,
  output logic [IDX_W-1:0]        grant_id,
  output logic [CNT_W-1:0]        conflict_cnt
);

  logic [IDX_W-1:0]      rr_ptr;
  logic [NREQ-1:0]       gnt;
  logic [IDX_W-1:0]      win_idx;
  logic                  xfer;
  logic                  win_we;
  logic [REG_ADDR_W-1:0] win_wa;
  logic [WIDTH-1:0]      win_wd;
  logic [IDX_W:0]        nvalid;
  logic                  conflict;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (gnt),
    .grant_idx (win_idx)
  );

  // Grants are masked while reset is held so nothing is accepted then
  assign req_ready = rst ? '0 : gnt;
  assign xfer      = |req_ready;

  always_comb begin
    win_wa = '0;
    win_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        win_wa = req_wa[REG_ADDR_W*i +: REG_ADDR_W];
        win_wd = req_wd[WIDTH*i +: WIDTH];
      end
    end
    // x0 writes are accepted but never reach the register file
    win_we = xfer && (win_wa != ZERO_REG);
  end

  always_comb begin
    nvalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      nvalid = nvalid + {{IDX_W{1'b0}}, req_valid[i]};
    end
    conflict = (nvalid >= (IDX_W+1)'(2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= IDX_W'(NREQ - 1);
      grant_id     <= '0;
      conflict_cnt <= '0;
    end else begin
      if (xfer) begin
        rr_ptr   <= win_idx;
        grant_id <= win_idx;
      end
      if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

`ifdef WB_ARB_OUTREG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= win_we;
      rf_wa <= win_wa;
      rf_wd <= win_wd;
    end
  end
`else
  assign rf_we = win_we;
  assign rf_wa = win_wa;
  assign rf_wd = win_wd;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench for regfile_wb_arbiter: a request-level model predicts
// each cycle's winner, a monitor compares DUT outputs against the queue.
module tb_regfile_wb_arbiter;

  localparam int WIDTH   = 32;
  localparam int NREQ    = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [NREQ-1:0]  ready;
    logic [2:0]       idx;
    logic             we;
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
    logic [CNT_W-1:0] cnt_after;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*5-1:0]     req_wa;
  logic [NREQ*WIDTH-1:0] req_wd;
  logic                  rf_we;
  logic [4:0]            rf_wa;
  logic [WIDTH-1:0]      rf_wd;
  logic [2:0]            grant_id;
  logic [CNT_W-1:0]      conflict_cnt;

  regfile_wb_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wa       (req_wa),
    .req_wd       (req_wd),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_q[$];

  // requester-side model state
  logic [NREQ-1:0] pv;
  logic [4:0]      pwa[NREQ];
  logic [WIDTH-1:0] pwd[NREQ];
  int ptr_m;
  int cnt_m;

  // monitor-side state
  logic [2:0]       gid_mon;
  logic [CNT_W-1:0] cnt_mon;
  logic             hold_we;
  logic [4:0]       hold_wa;
  logic [WIDTH-1:0] hold_wd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    req_valid = pv;
    for (int i = 0; i < NREQ; i++) begin
      req_wa[5*i +: 5]         = pwa[i];
      req_wd[WIDTH*i +: WIDTH] = pwd[i];
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] wa, input logic [WIDTH-1:0] wd);
    pv[i]  = 1'b1;
    pwa[i] = wa;
    pwd[i] = wd;
  endtask

  task automatic clear_model();
    exp_q.delete();
    ptr_m   = NREQ - 1;
    cnt_m   = 0;
    gid_mon = '0;
    cnt_mon = '0;
    hold_we = 1'b0;
    hold_wa = '0;
    hold_wd = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pv  = '0;
    drive_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // one bus cycle: refill requesters in 'fill', drive, predict, then retire the winner
  task automatic step(input logic [NREQ-1:0] fill);
    int w;
    int nv;
    exp_t e;
    logic [NREQ-1:0] one;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (fill[i] && !pv[i])
        set_req(i, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end
    drive_inputs();
    #1;
    w  = -1;
    nv = 0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (ptr_m + k) % NREQ;
      if (w < 0 && pv[c]) w = c;
    end
    for (int i = 0; i < NREQ; i++) nv += int'(pv[i]);
    if (nv >= 2 && cnt_m < CNT_MAX) cnt_m++;
    if (w >= 0) begin
      one         = 1;
      e.ready     = one << w;
      e.idx       = 3'(w);
      e.wa        = pwa[w];
      e.wd        = pwd[w];
      e.we        = (pwa[w] != 5'd0);
      e.cnt_after = CNT_W'(cnt_m);
      exp_q.push_back(e);
      ptr_m = w;
    end
    @(posedge clk);
    #1;
    if (w >= 0) pv[w] = 1'b0;
  endtask

  // monitor: samples mid-cycle, after inputs settle and before the next edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst) begin
        chk("grant_id", 64'(grant_id), 64'(gid_mon));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(cnt_mon));
`ifdef WB_ARB_OUTREG_EN
        chk("rf_we_reg", 64'(rf_we), 64'(hold_we));
        if (hold_we) begin
          chk("rf_wa_reg", 64'(rf_wa), 64'(hold_wa));
          chk("rf_wd_reg", 64'(rf_wd), 64'(hold_wd));
        end
`endif
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("req_ready", 64'(req_ready), 64'(e.ready));
`ifdef WB_ARB_OUTREG_EN
          hold_we = e.we;
          hold_wa = e.wa;
          hold_wd = e.wd;
`else
          chk("rf_we", 64'(rf_we), 64'(e.we));
          if (e.we) begin
            chk("rf_wa", 64'(rf_wa), 64'(e.wa));
            chk("rf_wd", 64'(rf_wd), 64'(e.wd));
          end
`endif
          gid_mon = e.idx;
          cnt_mon = e.cnt_after;
        end else begin
          chk("req_ready_idle", 64'(req_ready), 64'(0));
`ifdef WB_ARB_OUTREG_EN
          hold_we = 1'b0;
`else
          chk("rf_we_idle", 64'(rf_we), 64'(0));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    pv        = '0;
    req_valid = '0;
    req_wa    = '0;
    req_wd    = '0;
    for (int i = 0; i < NREQ; i++) begin
      pwa[i] = '0;
      pwd[i] = '0;
    end
    clear_model();
    do_reset();

    // idle after reset
    step('0);
    chk("t1_ready", 64'(req_ready), 64'(0));
    chk("t1_rf_we", 64'(rf_we), 64'(0));
    chk("t1_cnt", 64'(conflict_cnt), 64'(0));

    // single requester
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    step('0);
    chk("t2_grant_id", 64'(grant_id), 64'(1));
    step('0);

    // all three valid: grants 0,1,2 and two conflict cycles
    do_reset();
    set_req(0, 5'd7, 32'h1111_0000);
    set_req(1, 5'd8, 32'h2222_0000);
    set_req(2, 5'd7, 32'h3333_0000);
    repeat (3) step('0);
    chk("t3_cnt", 64'(conflict_cnt), 64'(2));
    chk("t3_grant_id", 64'(grant_id), 64'(2));

    // x0 write from requester 2
    set_req(2, 5'd0, 32'h0000_1234);
    step('0);
    step('0);

    // saturation: two requesters valid every cycle
    do_reset();
    repeat (20) step(3'b011);
    chk("t5_cnt_sat", 64'(conflict_cnt), 64'(CNT_MAX));
    repeat (4) step('0);

    // randomized traffic
    do_reset();
    repeat (400) step(NREQ'($urandom_range(0, (1 << NREQ) - 1)));
    repeat (2 * NREQ) step('0);

    // async reset with three requests pending
    set_req(0, 5'd1, 32'hA0A0_A0A0);
    set_req(1, 5'd2, 32'hB1B1_B1B1);
    set_req(2, 5'd3, 32'hC2C2_C2C2);
    @(negedge clk);
    drive_inputs();
    #2 rst = 1'b1;
    #1;
    chk("t6_ready", 64'(req_ready), 64'(0));
    chk("t6_rf_we", 64'(rf_we), 64'(0));
    chk("t6_rf_wa", 64'(rf_wa), 64'(0));
    chk("t6_rf_wd", 64'(rf_wd), 64'(0));
    chk("t6_grant_id", 64'(grant_id), 64'(0));
    chk("t6_cnt", 64'(conflict_cnt), 64'(0));
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step('0);
    chk("t6_first_grant", 64'(grant_id), 64'(0));
    repeat (2 * NREQ) step('0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
